// File: rtl/lowf_fir_mac_if.sv
// Stream, coefficient-ROM and result signals of the low-band FIR MAC stage.
// The master side is the queue/ROM/mixer environment; the slave side is the MAC.
interface lowf_fir_mac_if;
  logic               sequencing;
  logic signed [15:0] smpl_in;
  logic        [9:0]  coeff_addr;
  logic signed [15:0] coeff_in;
  logic signed [15:0] smpl_out;
  logic               valid_out;
  logic               abort;

  modport master (
    output sequencing, smpl_in, coeff_in,
    input  coeff_addr, smpl_out, valid_out, abort
  );

  modport slave (
    input  sequencing, smpl_in, coeff_in,
    output coeff_addr, smpl_out, valid_out, abort
  );
endinterface

// File: rtl/lowf_fir_mac.sv
// Serial multiply-accumulate FIR stage fed by the low-frequency sample queue.
// Optional macro LOWF_FIR_SAT_EN: saturate the 16-bit output instead of wrapping.
module lowf_fir_mac #(
  parameter int N_TAPS = 1021,
  parameter int ACC_W  = 42
) (
  input  logic           clk,
  input  logic           rst_n,
  lowf_fir_mac_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE,
    S_WAIT,
    S_ABORT
  } state_t;

  localparam logic [9:0] LAST_TAP = 10'(N_TAPS - 1);

  state_t                    state_q, state_d;
  logic        [9:0]         tap_q, tap_d;
  logic                      tap_v_q, tap_v_d;
  logic                      prod_v_q, prod_v_d;
  logic signed [31:0]        prod_q, prod_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic signed [ACC_W-1:0]   acc_sum;
  logic                      drain_q, drain_d;
  logic signed [15:0]        smpl_out_q, smpl_out_d;
  logic                      valid_out_q, valid_out_d;
  logic                      abort_q, abort_d;

`ifdef LOWF_FIR_SAT_EN
  localparam logic signed [ACC_W-16:0] OUT_MAX = (ACC_W-15)'(32767);
  localparam logic signed [ACC_W-16:0] OUT_MIN = -(ACC_W-15)'(32768);
  logic signed [ACC_W-16:0]  acc_shr;
`endif

  always_comb begin
    state_d     = state_q;
    tap_d       = tap_q;
    tap_v_d     = 1'b0;
    prod_v_d    = tap_v_q;
    prod_d      = 32'(bus.smpl_in) * 32'(bus.coeff_in);
    acc_sum     = acc_q + ACC_W'(prod_q);
    acc_d       = acc_q;
    drain_d     = 1'b0;
    smpl_out_d  = smpl_out_q;
    valid_out_d = 1'b0;
    abort_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Clearing here makes the first product of a pass overwrite old data.
        tap_d = '0;
        acc_d = '0;
        if (bus.sequencing) begin
          state_d = S_RUN;
          tap_d   = 10'd1;
          tap_v_d = 1'b1;
        end
      end
      S_RUN: begin
        if (prod_v_q) acc_d = acc_sum;
        if (bus.sequencing) begin
          tap_v_d = 1'b1;
          if (tap_q == LAST_TAP) state_d = S_DRAIN;
          else                   tap_d   = tap_q + 10'd1;
        end else begin
          state_d = S_ABORT;
          abort_d = 1'b1;
          tap_d   = '0;
          acc_d   = '0;
        end
      end
      S_DRAIN: begin
        if (prod_v_q) acc_d = acc_sum;
        drain_d = 1'b1;
        if (drain_q) begin
          state_d     = S_DONE;
          valid_out_d = 1'b1;
        end
      end
      S_DONE: begin
        if (bus.sequencing) begin
          state_d = S_WAIT;
        end else begin
          state_d = S_IDLE;
          tap_d   = '0;
        end
      end
      S_WAIT: begin
        if (!bus.sequencing) begin
          state_d = S_IDLE;
          tap_d   = '0;
        end
      end
      S_ABORT: begin
        acc_d   = '0;
        tap_d   = '0;
        state_d = bus.sequencing ? S_WAIT : S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        tap_d   = '0;
        acc_d   = '0;
      end
    endcase

    // The final product lands in acc_d on the same edge that raises valid_out.
`ifdef LOWF_FIR_SAT_EN
    acc_shr = acc_d[ACC_W-1:15];
    if (valid_out_d) begin
      if (acc_shr > OUT_MAX)      smpl_out_d = 16'sh7FFF;
      else if (acc_shr < OUT_MIN) smpl_out_d = -16'sh8000;
      else                        smpl_out_d = acc_shr[15:0];
    end
`else
    if (valid_out_d) smpl_out_d = acc_d[30:15];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      tap_q       <= '0;
      tap_v_q     <= 1'b0;
      prod_v_q    <= 1'b0;
      prod_q      <= '0;
      acc_q       <= '0;
      drain_q     <= 1'b0;
      smpl_out_q  <= '0;
      valid_out_q <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      tap_q       <= tap_d;
      tap_v_q     <= tap_v_d;
      prod_v_q    <= prod_v_d;
      prod_q      <= prod_d;
      acc_q       <= acc_d;
      drain_q     <= drain_d;
      smpl_out_q  <= smpl_out_d;
      valid_out_q <= valid_out_d;
      abort_q     <= abort_d;
    end
  end

  assign bus.coeff_addr = tap_q;
  assign bus.smpl_out   = smpl_out_q;
  assign bus.valid_out  = valid_out_q;
  assign bus.abort      = abort_q;

endmodule

// File: tb/tb_lowf_fir_mac.sv
// Bench for lowf_fir_mac: directed pass table, reset-mid-pass sequence and
// random passes checked against a sum-of-products reference model.
module tb_lowf_fir_mac;
  localparam int N = 1021;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lowf_fir_mac_if bus ();

  lowf_fir_mac #(.N_TAPS(N), .ACC_W(42)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  logic signed [15:0] coef_mem [0:1023];
  logic signed [15:0] samp_mem [0:2047];
  int sidx = 0;

  // Registered coefficient ROM and sample queue models.
  always @(posedge clk) begin
    bus.coeff_in <= coef_mem[bus.coeff_addr];
    if (bus.sequencing) begin
      bus.smpl_in <= samp_mem[sidx];
      sidx        <= sidx + 1;
    end else begin
      bus.smpl_in <= '0;
      sidx        <= 0;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: floor((sum of first N products) / 2^15), then wrap or clamp.
  function automatic logic [15:0] model_out();
    longint acc = 0;
    longint sh;
    for (int j = 0; j < N; j++)
      acc += longint'(samp_mem[j]) * longint'(coef_mem[j]);
    sh = acc >>> 15;
`ifdef LOWF_FIR_SAT_EN
    if (sh > 32767)  sh = 32767;
    if (sh < -32768) sh = -32768;
`endif
    return 16'(sh);
  endfunction

  task automatic fill(input logic [15:0] c0, input logic [15:0] cr,
                      input logic [15:0] s0, input logic [15:0] sr);
    for (int j = 0; j < 1024; j++) coef_mem[j] = (j == 0) ? c0 : cr;
    for (int j = 0; j < 2048; j++) samp_mem[j] = (j == 0) ? s0 : sr;
  endtask

  // Drives one pass of seq_len sequencing cycles and checks everything it produces.
  task automatic run_pass(input string nm, input int seq_len,
                          input logic [15:0] exp_out, input bit exp_valid);
    int end_c, zero_c, vcnt, vcyc, acnt, addr_err, exp_addr;
    logic [15:0] vval;
    logic [15:0] so;
    end_c = (seq_len > N + 2) ? seq_len : N + 2;
    zero_c = end_c + 1;
    vcnt = 0; vcyc = -1; acnt = 0; addr_err = 0; vval = '0;
    for (int c = 0; c < end_c + 4; c++) begin
      @(negedge clk);
      if (bus.valid_out) begin
        vcnt++;
        vcyc = c;
        vval = bus.smpl_out;
      end
      if (bus.abort) acnt++;
      if (bus.coeff_addr > 10'(N - 1)) addr_err++;
      if (c < seq_len) begin
        exp_addr = (c < N) ? c : N - 1;
        if (int'(bus.coeff_addr) != exp_addr) addr_err++;
      end
      if (c == zero_c) chk({nm, "_addr_zero"}, 64'(bus.coeff_addr), 64'd0);
      bus.sequencing = (c < seq_len);
    end
    bus.sequencing = 1'b0;
    so = bus.smpl_out;
    chk({nm, "_valid_cnt"}, 64'(vcnt), exp_valid ? 64'd1 : 64'd0);
    chk({nm, "_abort_cnt"}, 64'(acnt), exp_valid ? 64'd0 : 64'd1);
    chk({nm, "_addr_seq"}, 64'(addr_err), 64'd0);
    chk({nm, "_smpl_out"}, 64'(so), 64'(exp_out));
    if (exp_valid) begin
      chk({nm, "_latency"}, 64'(vcyc), 64'(N + 2));
      chk({nm, "_valid_data"}, 64'(vval), 64'(exp_out));
    end
    $display("pass %s: len=%0d valid=%0d at cycle %0d out=%h abort=%0d",
             nm, seq_len, vcnt, vcyc, so, acnt);
  endtask

  typedef struct {
    string       name;
    int          seq_len;
    logic [15:0] c0, cr, s0, sr;
    logic [15:0] exp_out;
    bit          exp_valid;
  } vec_t;

`ifdef LOWF_FIR_SAT_EN
  localparam logic [15:0] OVF_OUT = 16'h7FFF;
`else
  localparam logic [15:0] OVF_OUT = 16'h7806;
`endif

  vec_t vecs [7];

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] exp;
    int len;

    vecs[0] = '{"impulse",     N,    16'h7FFF, 16'h0000, 16'h4000, 16'h0000, 16'h3FFF, 1'b1};
    vecs[1] = '{"dc_gain",     N,    16'h0020, 16'h0020, 16'h0100, 16'h0100, 16'h00FF, 1'b1};
    vecs[2] = '{"neg_impulse", N,    16'h7FFF, 16'h0000, 16'hC000, 16'h0000, 16'hC000, 1'b1};
    vecs[3] = '{"overflow",    N,    16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, OVF_OUT,  1'b1};
    vecs[4] = '{"short",       500,  16'h1234, 16'h1234, 16'h2345, 16'h2345, OVF_OUT,  1'b0};
    vecs[5] = '{"after_short", N,    16'h7FFF, 16'h0000, 16'h4000, 16'h0000, 16'h3FFF, 1'b1};
    vecs[6] = '{"long",        1100, 16'h0020, 16'h0020, 16'h0100, 16'h0100, 16'h00FF, 1'b1};

    bus.sequencing = 1'b0;
    fill(16'h0, 16'h0, 16'h0, 16'h0);
    repeat (3) @(negedge clk);
    chk("reset_smpl_out", 64'($unsigned(bus.smpl_out)), 64'd0);
    chk("reset_valid", 64'(bus.valid_out), 64'd0);
    chk("reset_abort", 64'(bus.abort), 64'd0);
    chk("reset_addr", 64'(bus.coeff_addr), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      fill(vecs[i].c0, vecs[i].cr, vecs[i].s0, vecs[i].sr);
      run_pass(vecs[i].name, vecs[i].seq_len, vecs[i].exp_out, vecs[i].exp_valid);
    end

    // Reset at tap 600 of an impulse pass, then a clean impulse pass.
    fill(16'h7FFF, 16'h0000, 16'h4000, 16'h0000);
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      bus.sequencing = 1'b1;
    end
    @(negedge clk);
    chk("pre_reset_addr", 64'(bus.coeff_addr), 64'd600);
    rst_n = 1'b0;
    bus.sequencing = 1'b0;
    #1;
    chk("mid_reset_smpl_out", 64'($unsigned(bus.smpl_out)), 64'd0);
    chk("mid_reset_addr", 64'(bus.coeff_addr), 64'd0);
    chk("mid_reset_valid", 64'(bus.valid_out), 64'd0);
    chk("mid_reset_abort", 64'(bus.abort), 64'd0);
    $display("reset asserted at tap 600: out=%h addr=%0d", bus.smpl_out, bus.coeff_addr);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    begin
      int spurious = 0;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (bus.valid_out || bus.abort) spurious++;
      end
      chk("post_reset_quiet", 64'(spurious), 64'd0);
    end
    run_pass("impulse_after_reset", N, 16'h3FFF, 1'b1);

    // Random passes against the reference model.
    for (int r = 0; r < 4; r++) begin
      for (int j = 0; j < 1024; j++) coef_mem[j] = 16'($urandom);
      for (int j = 0; j < 2048; j++) samp_mem[j] = 16'($urandom);
      if (r == 1) begin
        for (int j = 0; j < 1024; j++) coef_mem[j] = 16'($urandom_range(0, 255)) - 16'd128;
      end
      exp = model_out();
      len = (r == 3) ? N + 40 : N;
      run_pass($sformatf("random%0d", r), len, exp, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/lowf_fir_mac.md
Name: lowf_fir_mac

Overview:
- Serial multiply-accumulate FIR stage directly downstream of the low-frequency circular sample queue.
- While the queue asserts sequencing, it streams one buffered sample per clk. This block pairs each sample with a coefficient from an external registered coefficient ROM and accumulates the products.
- At the end of each pass it emits one filtered 16-bit low-band sample to the band mixer/volume stage.

Parameters:
- N_TAPS, 1021, samples per pass and number of coefficients (max 1024).
- ACC_W, 42, signed accumulator width (32-bit product + 10 guard bits).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- sequencing  in  1  high while queue streams samples, one per clk
- smpl_in  in  16  signed sample from queue RAM; valid one clk after the matching sequencing cycle
- coeff_addr  out  10  coefficient ROM address
- coeff_in  in  16  signed Q1.15 coefficient; registered ROM, one-clk latency
- smpl_out  out  16  signed filtered sample, held until next result
- valid_out  out  1  one-clk pulse when smpl_out updates
- abort  out  1  one-clk pulse when a pass ends short

Behaviour:
- Clock and reset: clk; rst_n asynchronous, active-low.
- Reset values: smpl_out=0, valid_out=0, abort=0, coeff_addr=0, accumulator=0, tap counter=0, state IDLE.
- States:
  - IDLE: coeff_addr=0. sequencing=1 → RUN; this cycle is tap 0.
  - RUN: in tap cycle k, coeff_addr=k.
    - sequencing=1 and k<N_TAPS-1 → k+1.
    - k reaches N_TAPS-1 with sequencing=1 → DRAIN.
    - sequencing=0 while k<N_TAPS-1 → ABORT.
  - DRAIN: finish the pipeline (2 clks), then DONE.
  - DONE: load smpl_out, pulse valid_out → WAIT.
  - WAIT: ignore sequencing until it deasserts → IDLE. Extra samples beyond N_TAPS are not accumulated.
  - ABORT: pulse abort; clear accumulator and counter; smpl_out unchanged; no valid_out → IDLE (or WAIT if sequencing is high again).
- Pipeline:
  - Tap k address issued in cycle k.
  - smpl_in and coeff_in for tap k are sampled in cycle k+1.
  - Signed 16x16 product registered at end of cycle k+1.
  - Product added to accumulator in cycle k+2.
  - Accumulator cleared on entry to RUN; first add overwrites rather than sums stale data.
- Latency: first sequencing cycle = cycle 0; valid_out in cycle N_TAPS+2 (1023 at default).
- Arithmetic:
  - Products are full 32-bit signed.
  - Accumulator sign-extends to ACC_W and never wraps for N_TAPS ≤ 1024.
  - Output = acc[30:15], arithmetic shift right by 15, floor (no rounding).
- Reset mid-pass: all state cleared immediately; no valid_out or abort is generated for the interrupted pass.
- coeff_addr never exceeds N_TAPS-1.

Optional Feature:
- Macro: LOWF_FIR_SAT_EN.
- Defined: if acc exceeds the 16-bit range after the >>15, smpl_out saturates to 0x7FFF (positive) or 0x8000 (negative).
- Undefined: smpl_out = acc[30:15] truncated; overflow wraps.

Test Plan:
1. Impulse: coeff[0]=0x7FFF, others 0; first sample 0x4000, rest 0; sequencing high 1021 clks → valid_out at cycle 1023, smpl_out=0x3FFF.
2. DC gain: all coeffs 0x0020, all samples 0x0100 → acc=1021*8192=8,364,032 → smpl_out=0x00FF.
3. Overflow: all coeffs 0x7FFF, all samples 0x7FFF.
   - LOWF_FIR_SAT_EN defined → 0x7FFF.
   - Undefined → acc[30:15] of 1021*0x3FFF0001 (wrapped value).
4. Short pass: sequencing drops after 500 clks → abort pulses once, no valid_out, smpl_out keeps previous value; next full pass is correct.
5. Long pass: sequencing high 1100 clks → exactly one valid_out at cycle 1023; coeff_addr saturates at 1020, then 0 after sequencing falls.
6. Reset at tap 600 → all outputs 0 asynchronously; a following full impulse pass yields 0x3FFF.
